burst_slave_rw: RTL

BURST_SLAVE_RW -- requirements
Module: burst_slave_rw

---
 rtl/burst_slave_rw.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/burst_slave_rw.sv
// burst_slave_rw
//   Avalon-MM burst slave backed by a small on-chip word memory.
//   Write bursts are accepted one beat per cycle with byte-lane masking and
//   may contain idle cycles between beats. Read bursts return one beat per
//   cycle starting one cycle after the request; waitrequest stalls the
//   master for the duration of a read burst. Burst addresses wrap inside
//   the memory, and upper address bits beyond the memory index are ignored.
//
// Ports
//   clk_i              in   1                single clock, rising edge
//   rst_i              in   1                asynchronous active-high reset
//   avms_address       in   AW               burst start word address
//   avms_burstcount    in   BURSTCOUNTWIDTH  beats in burst (0 means 1)
//   avms_write         in   1                write request / write beat
//   avms_writedata     in   DW               write beat data
//   avms_byteenable    in   BYTEENABLEWIDTH  per-lane write enable
//   avms_read          in   1                read burst request
//   avms_waitrequest   out  1                slave stall (high during reads)
//   avms_readdata      out  DW               read beat data
//   avms_readdatavalid out  1                readdata qualifier
module burst_slave_rw #(
  parameter int DW              = 32,
  parameter int AW              = 16,
  parameter int MEM_AW          = 6,
  parameter int BURSTCOUNTWIDTH = 4,
  parameter int BYTEENABLEWIDTH = DW / 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [AW-1:0]              avms_address,
  input  logic [BURSTCOUNTWIDTH-1:0] avms_burstcount,
  input  logic                       avms_write,
  input  logic [DW-1:0]              avms_writedata,
  input  logic [BYTEENABLEWIDTH-1:0] avms_byteenable,
  input  logic                       avms_read,
  output logic                       avms_waitrequest,
  output logic [DW-1:0]              avms_readdata,
  output logic                       avms_readdatavalid
);

  // One extra bit so that a full-length burst count never overflows.
  localparam int CW    = BURSTCOUNTWIDTH + 1;
  localparam int DEPTH = 1 << MEM_AW;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WR_BURST = 2'd1,
    RD_BURST = 2'd2
  } state_t;

  state_t              state_r;
  logic [MEM_AW-1:0]   idx_r;
  logic [CW-1:0]       cnt_r;
  logic [CW-1:0]       len_r;
  logic [DW-1:0]       mem_r [DEPTH];

  logic [MEM_AW-1:0]   cmd_idx_s;
  logic [CW-1:0]       cmd_len_s;

  // A burstcount of zero is treated as a single beat.
  function automatic logic [CW-1:0] beats_of(input logic [BURSTCOUNTWIDTH-1:0] bc);
    if (bc == {BURSTCOUNTWIDTH{1'b0}}) begin
      return CW'(1);
    end else begin
      return {1'b0, bc};
    end
  endfunction

  // Replace only the byte lanes whose enable bit is set.
  function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0]              old_word,
                                               input logic [DW-1:0]              new_word,
                                               input logic [BYTEENABLEWIDTH-1:0] be);
    logic [DW-1:0] merged;
    merged = old_word;
    for (int b = 0; b < BYTEENABLEWIDTH; b++) begin
      if (be[b]) begin
        merged[b*8 +: 8] = new_word[b*8 +: 8];
      end else begin
        merged[b*8 +: 8] = old_word[b*8 +: 8];
      end
    end
    return merged;
  endfunction

  // Decode the command index and effective burst length from the bus.
  always_comb begin
    cmd_idx_s = avms_address[MEM_AW-1:0];
    cmd_len_s = beats_of(avms_burstcount);
  end

  // Upper address bits only alias onto the memory; they carry no function.
  generate
    if (AW > MEM_AW) begin : g_unused_addr
      logic unused_addr_s;
      assign unused_addr_s = ^avms_address[AW-1:MEM_AW];
    end
  endgenerate

  // Burst FSM, memory array and registered bus outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r            <= IDLE;
      idx_r              <= {MEM_AW{1'b0}};
      cnt_r              <= {CW{1'b0}};
      len_r              <= {CW{1'b0}};
      avms_waitrequest   <= 1'b0;
      avms_readdatavalid <= 1'b0;
      avms_readdata      <= {DW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {DW{1'b0}};
      end
    end else begin
      case (state_r)
        IDLE: begin
          avms_readdatavalid <= 1'b0;
          avms_waitrequest   <= 1'b0;
          if (avms_write) begin
            // First write beat lands on this edge; a pending read is dropped.
            mem_r[cmd_idx_s] <= lane_merge(mem_r[cmd_idx_s], avms_writedata, avms_byteenable);
            idx_r            <= cmd_idx_s + MEM_AW'(1);
            len_r            <= cmd_len_s;
            if (cmd_len_s <= CW'(1)) begin
              state_r <= IDLE;
              cnt_r   <= {CW{1'b0}};
            end else begin
              state_r <= WR_BURST;
              cnt_r   <= CW'(1);
            end
          end else if (avms_read) begin
            // First read beat is launched on the accepting edge.
            avms_readdata      <= mem_r[cmd_idx_s];
            avms_readdatavalid <= 1'b1;
            avms_waitrequest   <= 1'b1;
            idx_r              <= cmd_idx_s + MEM_AW'(1);
            cnt_r              <= CW'(1);
            len_r              <= cmd_len_s;
            state_r            <= RD_BURST;
          end else begin
            state_r <= IDLE;
          end
        end

        WR_BURST: begin
          avms_readdatavalid <= 1'b0;
          avms_waitrequest   <= 1'b0;
          if (avms_write) begin
            mem_r[idx_r] <= lane_merge(mem_r[idx_r], avms_writedata, avms_byteenable);
            idx_r        <= idx_r + MEM_AW'(1);
            if (cnt_r + CW'(1) == len_r) begin
              state_r <= IDLE;
              cnt_r   <= {CW{1'b0}};
            end else begin
              state_r <= WR_BURST;
              cnt_r   <= cnt_r + CW'(1);
            end
          end else begin
            state_r <= WR_BURST;
          end
        end

        RD_BURST: begin
          // Bus commands are ignored here; waitrequest stays high until the
          // cycle after the final beat so the master cannot slip a command in.
          if (cnt_r < len_r) begin
            avms_readdata      <= mem_r[idx_r];
            avms_readdatavalid <= 1'b1;
            avms_waitrequest   <= 1'b1;
            idx_r              <= idx_r + MEM_AW'(1);
            cnt_r              <= cnt_r + CW'(1);
            state_r            <= RD_BURST;
          end else begin
            avms_readdatavalid <= 1'b0;
            avms_waitrequest   <= 1'b0;
            cnt_r              <= {CW{1'b0}};
            state_r            <= IDLE;
          end
        end

        default: begin
          state_r            <= IDLE;
          avms_readdatavalid <= 1'b0;
          avms_waitrequest   <= 1'b0;
          cnt_r              <= {CW{1'b0}};
        end
      endcase
    end
  end

endmodule
